// File: rtl/bin2bcd_seq_if.sv
// Conversion bus for bin2bcd_seq: load/operand in, handshake and BCD result out.
interface bin2bcd_seq_if #(
   parameter int BIN_WIDTH = 32,
   parameter int DIGITS    = 10
);
   logic                   load;
   logic [BIN_WIDTH-1:0]   binaryNumber;
   logic                   busy;
   logic                   done;
   logic [DIGITS-1:0][3:0] BinaryDecimal;
   logic                   overflow;
   logic                   negative;

   modport master (output load, binaryNumber,
                   input  busy, done, BinaryDecimal, overflow, negative);
   modport slave  (input  load, binaryNumber,
                   output busy, done, BinaryDecimal, overflow, negative);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional two's-complement input when BIN2BCD_SIGNED_INPUT_EN is defined.
module bin2bcd_seq #(
   parameter int BIN_WIDTH = 32,
   parameter int DIGITS    = 10
) (
   input  logic         clk,
   input  logic         rst,
   bin2bcd_seq_if.slave bus
);
   localparam int AW = DIGITS * 4;
   localparam int CW = $clog2(BIN_WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 r_state, w_next;
   logic [BIN_WIDTH-1:0]   r_sr;
   logic [AW-1:0]          r_acc;
   logic [CW-1:0]          r_cnt;
   logic                   r_ovf_stk;
   logic                   r_busy, r_done, r_ovf;
   logic [DIGITS-1:0][3:0] r_bcd;
   logic [BIN_WIDTH-1:0]   w_mag;
   logic [AW-1:0]          w_adj;
   logic [AW-1:0]          w_shift;
   logic                   w_top;

`ifdef BIN2BCD_SIGNED_INPUT_EN
   logic w_sign, r_sign, r_neg;
   assign w_sign = bus.binaryNumber[BIN_WIDTH-1];
   assign w_mag  = w_sign ? (~bus.binaryNumber + {{(BIN_WIDTH-1){1'b0}}, 1'b1})
                          : bus.binaryNumber;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sign <= 1'b0;
         r_neg  <= 1'b0;
      end else if (bus.load) begin
         r_sign <= w_sign;
      end else if (r_state == SHIFT && r_cnt == '0) begin
         r_neg  <= r_sign;
      end
   end
   assign bus.negative = r_neg;
`else
   assign w_mag        = bus.binaryNumber;
   assign bus.negative = 1'b0;
`endif

   // Per-digit +3 correction; digits are independent, no inter-digit carry.
   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      assign w_adj[d*4 +: 4] = (r_acc[d*4 +: 4] >= 4'd5) ? r_acc[d*4 +: 4] + 4'd3
                                                          : r_acc[d*4 +: 4];
   end

   assign w_top   = w_adj[AW-1];
   assign w_shift = {w_adj[AW-2:0], r_sr[BIN_WIDTH-1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (bus.load)                              w_next = SHIFT;
      else if (r_state == SHIFT && r_cnt == '0)  w_next = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr      <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf_stk <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_bcd     <= '0;
      end else if (bus.load) begin
         // A load in SHIFT simply restarts; the aborted result is discarded.
         r_sr      <= w_mag;
         r_acc     <= '0;
         r_ovf_stk <= 1'b0;
         r_cnt     <= CW'(BIN_WIDTH - 1);
         r_busy    <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == SHIFT) begin
            r_acc     <= w_shift;
            r_sr      <= {r_sr[BIN_WIDTH-2:0], 1'b0};
            r_cnt     <= r_cnt - 1'b1;
            r_ovf_stk <= r_ovf_stk | w_top;
            if (r_cnt == '0) begin
               r_bcd  <= w_shift;
               r_ovf  <= r_ovf_stk | w_top;
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.overflow      = r_ovf;
   assign bus.BinaryDecimal = r_bcd;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against an arithmetic reference.
module tb_bin2bcd_seq;
   localparam int BW = 10;
   localparam int D  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   logic [63:0] prev_bcd = '0;
   bit          have_prev = 1'b0;

   bin2bcd_seq_if #(.BIN_WIDTH(BW), .DIGITS(D)) bus ();
   bin2bcd_seq #(.BIN_WIDTH(BW), .DIGITS(D)) u_dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Decimal value mod 10^D, overflow if it does not fit, sign of two's-complement input.
   function automatic void model(input longint v, output logic [63:0] bcd,
                                 output logic ov, output logic ng);
      longint mag = v;
      longint lim = 1;
      ng = 1'b0;
`ifdef BIN2BCD_SIGNED_INPUT_EN
      if (v >= (longint'(1) << (BW-1))) begin
         ng  = 1'b1;
         mag = (longint'(1) << BW) - v;
      end
`endif
      for (int i = 0; i < D; i++) lim = lim * 10;
      ov  = (mag >= lim);
      mag = mag % lim;
      bcd = '0;
      for (int i = 0; i < D; i++) begin
         bcd[i*4 +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
   endfunction

   // Called at a negedge; loads v, waits for done, checks latency, busy span and results.
   task automatic conv(input longint v);
      logic [63:0] e_bcd;
      logic        e_ov, e_ng;
      int          n, busy_cnt;
      model(v, e_bcd, e_ov, e_ng);
      bus.load = 1'b1;
      bus.binaryNumber = BW'(v);
      @(negedge clk);
      bus.load = 1'b0;
      n = 1;
      busy_cnt = 0;
      while (!bus.done && n < 4*BW) begin
         if (bus.busy) busy_cnt++;
         if (have_prev && n == BW/2) chk("hold", 64'(bus.BinaryDecimal), prev_bcd);
         @(negedge clk);
         n++;
      end
      chk("latency", 64'(n), 64'(BW+1));
      chk("busy_cycles", 64'(busy_cnt), 64'(BW));
      chk("busy_at_done", 64'(bus.busy), 64'(0));
      chk("bcd", 64'(bus.BinaryDecimal), e_bcd);
      chk("overflow", 64'(bus.overflow), 64'(e_ov));
      chk("negative", 64'(bus.negative), 64'(e_ng));
      prev_bcd  = e_bcd;
      have_prev = 1'b1;
   endtask

   initial begin
      longint dir[] = '{255, 0, 9, 99, 100, 999, 1000, 1023, 512, 511, 1, 384};
      int dn;
      bus.load = 1'b0;
      bus.binaryNumber = '0;
      #12;
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_done", 64'(bus.done), 0);
      chk("rst_bcd", 64'(bus.BinaryDecimal), 0);
      chk("rst_ovf", 64'(bus.overflow), 0);
      chk("rst_neg", 64'(bus.negative), 0);
      // load during reset must be ignored
      bus.load = 1'b1;
      @(negedge clk);
      chk("rst_load_busy", 64'(bus.busy), 0);
      bus.load = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      foreach (dir[i]) begin
         conv(dir[i]);
         @(negedge clk);
         chk("done_pulse", 64'(bus.done), 0);
      end

      // back-to-back: new load in the cycle done is high
      conv(0);
      conv(9);
      for (int i = 0; i < 10; i++) conv(longint'($urandom_range(0, (1 << BW) - 1)));
      @(negedge clk);

      // abort: reload four cycles in, only one done expected
      bus.load = 1'b1;
      bus.binaryNumber = BW'(345);
      @(negedge clk);
      bus.load = 1'b0;
      dn = 0;
      repeat (3) begin
         if (bus.done) dn++;
         @(negedge clk);
      end
      chk("abort_no_done", 64'(dn), 0);
      conv(1023);
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         conv(longint'($urandom_range(0, (1 << BW) - 1)));
      end
      @(negedge clk);

      // asynchronous reset mid-conversion
      bus.load = 1'b1;
      bus.binaryNumber = BW'(777);
      @(negedge clk);
      bus.load = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 64'(bus.busy), 0);
      chk("arst_done", 64'(bus.done), 0);
      chk("arst_bcd", 64'(bus.BinaryDecimal), 0);
      chk("arst_ovf", 64'(bus.overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (2*BW) begin
         @(negedge clk);
         if (bus.done || bus.busy) dn++;
      end
      chk("arst_quiet", 64'(dn), 0);
      have_prev = 1'b0;
      conv(255);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
